// File: rtl/l1_set_assoc.sv
// Set-associative write-back L1: hits answer in 1 cycle; misses write back a dirty victim and then refill the line.
// Backpressure: mem_ready low stalls the current word with address and data held; requests outside IDLE are dropped.
module l1_set_assoc #(
    parameter int WAYS           = 2,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        request,
    input  logic        should_write,
    input  logic [31:0] address,
    input  logic [31:0] input_data,
    output logic [31:0] output_data,
    output logic        ready,
    output logic        mem_request,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready
);

    localparam int OFF   = $clog2(WORDS_PER_LINE) + 2;
    localparam int IDXW  = $clog2(SETS);
    localparam int TAGW  = 32 - OFF - IDXW;
    localparam int WORDW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int WAYW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_t;

    function automatic logic [IDXW-1:0] idx_of(input logic [31:0] a);
        return IDXW'(a >> OFF);
    endfunction

    function automatic logic [TAGW-1:0] tag_of(input logic [31:0] a);
        return TAGW'(a >> (OFF + IDXW));
    endfunction

    function automatic logic [WORDW-1:0] word_of(input logic [31:0] a);
        return WORDW'((a >> 2) & 32'(WORDS_PER_LINE - 1));
    endfunction

    state_t                       state_q, state_d;
    logic [31:0]                  addr_q, addr_d;
    logic                         wr_q, wr_d;
    logic [31:0]                  wdat_q, wdat_d;
    logic [WAYW-1:0]              victim_q, victim_d;
    logic [WORDW-1:0]             cnt_q, cnt_d;
    logic                         ready_q, ready_d;
    logic [31:0]                  rdata_q, rdata_d;
    logic [WAYS-1:0][SETS-1:0]    valid_q, valid_d;
    logic [WAYS-1:0][SETS-1:0]    dirty_q, dirty_d;
    logic [SETS-1:0][WAYW-1:0]    rr_q, rr_d;

    // Line storage is not reset; valid bits alone decide whether contents count.
    logic [31:0]     data_mem [WAYS][SETS][WORDS_PER_LINE];
    logic [TAGW-1:0] tag_mem  [WAYS][SETS];

    logic             data_we;
    logic [WAYW-1:0]  data_way;
    logic [IDXW-1:0]  data_idx;
    logic [WORDW-1:0] data_word;
    logic [31:0]      data_wdat;
    logic             tag_we;

    logic [IDXW-1:0]  in_idx, r_idx;
    logic [TAGW-1:0]  in_tag, r_tag;
    logic [WORDW-1:0] in_word, r_word;
    logic             hit, has_inv, last_word;
    logic [WAYW-1:0]  hit_way, inv_way, rr_way, rr_next;

    assign in_idx    = idx_of(address);
    assign in_tag    = tag_of(address);
    assign in_word   = word_of(address);
    assign r_idx     = idx_of(addr_q);
    assign r_tag     = tag_of(addr_q);
    assign r_word    = word_of(addr_q);
    assign last_word = (cnt_q == WORDW'(WORDS_PER_LINE - 1));
    assign rr_way    = rr_q[in_idx];
    assign rr_next   = (rr_way == WAYW'(WAYS - 1)) ? '0 : rr_way + WAYW'(1);

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][in_idx] && (tag_mem[w][in_idx] == in_tag)) begin
                hit     = 1'b1;
                hit_way = WAYW'(w);
            end
            if (!valid_q[w][in_idx]) begin
                has_inv = 1'b1;
                inv_way = WAYW'(w);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wr_d           = wr_q;
        wdat_d         = wdat_q;
        victim_d       = victim_q;
        cnt_d          = cnt_q;
        ready_d        = 1'b0;
        rdata_d        = rdata_q;
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        rr_d           = rr_q;
        data_we        = 1'b0;
        data_way       = victim_q;
        data_idx       = r_idx;
        data_word      = cnt_q;
        data_wdat      = mem_read_data;
        tag_we         = 1'b0;
        mem_request    = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;

        case (state_q)
            IDLE: begin
                if (request && !ready_q) begin
                    addr_d = address;
                    wr_d   = should_write;
                    wdat_d = input_data;
                    cnt_d  = '0;
                    if (hit) begin
                        ready_d = 1'b1;
                        if (should_write) begin
                            data_we                  = 1'b1;
                            data_way                 = hit_way;
                            data_idx                 = in_idx;
                            data_word                = in_word;
                            data_wdat                = input_data;
                            dirty_d[hit_way][in_idx] = 1'b1;
                        end else begin
                            rdata_d = data_mem[hit_way][in_idx][in_word];
                        end
                    end else if (has_inv) begin
                        victim_d = inv_way;
                        state_d  = REFILL;
                    end else begin
                        victim_d       = rr_way;
                        rr_d[in_idx]   = rr_next;
                        state_d        = dirty_q[rr_way][in_idx] ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                mem_request    = 1'b1;
                mem_write      = 1'b1;
                mem_address    = {tag_mem[victim_q][r_idx], r_idx, {OFF{1'b0}}} | (32'(cnt_q) << 2);
                mem_write_data = data_mem[victim_q][r_idx][cnt_q];
                if (mem_ready) begin
                    cnt_d = cnt_q + WORDW'(1);
                    if (last_word) begin
                        cnt_d                    = '0;
                        dirty_d[victim_q][r_idx] = 1'b0;
                        state_d                  = REFILL;
                    end
                end
            end
            REFILL: begin
                mem_request = 1'b1;
                mem_address = {r_tag, r_idx, {OFF{1'b0}}} | (32'(cnt_q) << 2);
                if (mem_ready) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + WORDW'(1);
                    if (cnt_q == r_word) begin
                        rdata_d = mem_read_data;
                    end
                    if (last_word) begin
                        cnt_d                    = '0;
                        tag_we                   = 1'b1;
                        valid_d[victim_q][r_idx] = 1'b1;
                        dirty_d[victim_q][r_idx] = 1'b0;
                        ready_d                  = 1'b1;
                        state_d                  = RESPOND;
                    end
                end
            end
            RESPOND: begin
                state_d = IDLE;
                if (wr_q) begin
                    data_we                  = 1'b1;
                    data_word                = r_word;
                    data_wdat                = wdat_q;
                    dirty_d[victim_q][r_idx] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdat_q   <= '0;
            victim_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
            rr_q     <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            wdat_q   <= wdat_d;
            victim_q <= victim_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            rr_q     <= rr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (data_we) begin
            data_mem[data_way][data_idx][data_word] <= data_wdat;
        end
        if (tag_we) begin
            tag_mem[victim_q][r_idx] <= r_tag;
        end
    end

    assign ready       = ready_q;
    assign output_data = rdata_q;

endmodule

// File: tb/tb_l1_set_assoc.sv
// Directed bench for l1_set_assoc: memory word at byte address A returns 0xA000_0000 + A/4.
module tb_l1_set_assoc;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        request = 1'b0;
    logic        should_write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] input_data = '0;
    logic [31:0] output_data;
    logic        ready;
    logic        mem_request;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_ready;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
    } xfer_t;

    xfer_t xfers[$];
    bit    saw_req;
    int    n_vec = 0;
    int    n_bad = 0;
    bit    stall_en = 1'b0;
    int    stall_cnt = 0;
    int    stall_addr_bad = 0;

    l1_set_assoc dut (
        .clock          (clock),
        .reset          (reset),
        .request        (request),
        .should_write   (should_write),
        .address        (address),
        .input_data     (input_data),
        .output_data    (output_data),
        .ready          (ready),
        .mem_request    (mem_request),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready)
    );

    always #5 clock = ~clock;

    assign mem_read_data = 32'hA000_0000 + (mem_address >> 2);
    assign mem_ready = !(stall_en && mem_request && !mem_write &&
                         (mem_address[3:2] == 2'd2) && (stall_cnt < 5));

    always @(posedge clock) begin
        if (!stall_en) begin
            stall_cnt <= 0;
        end
        if (!reset) begin
            if (mem_request) saw_req = 1'b1;
            if (mem_request && mem_ready) begin
                xfers.push_back('{wr: mem_write, a: mem_address, d: mem_write_data});
            end
            if (stall_en && mem_request && !mem_ready) begin
                stall_cnt <= stall_cnt + 1;
                if (mem_address !== 32'h0000_0318) stall_addr_bad++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_log(input string tag, input int n_wr, input logic [31:0] wb,
                             input int n_rd, input logic [31:0] rb);
        chk({tag, ".count"}, 32'(xfers.size()), 32'(n_wr + n_rd));
        for (int i = 0; i < n_wr + n_rd && i < xfers.size(); i++) begin
            if (i < n_wr) begin
                chk({tag, ".wr"}, 32'(xfers[i].wr), 32'd1);
                chk({tag, ".wb_addr"}, xfers[i].a, wb + 32'(4 * i));
            end else begin
                chk({tag, ".rd"}, 32'(xfers[i].wr), 32'd0);
                chk({tag, ".rd_addr"}, xfers[i].a, rb + 32'(4 * (i - n_wr)));
            end
        end
    endtask

    task automatic access(input logic [31:0] a, input logic wr, input logic [31:0] d,
                          input int pulse_at, output int cyc, output logic [31:0] rd);
        @(posedge clock);
        #1;
        xfers.delete();
        saw_req      = 1'b0;
        address      = a;
        should_write = wr;
        input_data   = d;
        request      = 1'b1;
        cyc          = 0;
        rd           = '0;
        while (cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
            if (ready) begin
                rd = output_data;
                break;
            end
            if (cyc == pulse_at) begin
                address      = 32'h0000_0640;
                should_write = 1'b1;
                input_data   = 32'h5555_AAAA;
            end else if (cyc == pulse_at + 1) begin
                address      = a;
                should_write = wr;
                input_data   = d;
            end
        end
        chk("access.ready", 32'(ready), 32'd1);
        request = 1'b0;
    endtask

    initial begin
        int          cyc;
        logic [31:0] rd;

        #22;
        chk("rst.ready", 32'(ready), 32'd0);
        chk("rst.mem_request", 32'(mem_request), 32'd0);
        chk("rst.mem_write", 32'(mem_write), 32'd0);
        chk("rst.mem_address", mem_address, 32'd0);
        chk("rst.output_data", output_data, 32'd0);
        reset = 1'b0;

        access(32'h0000_0100, 1'b0, '0, -1, cyc, rd);
        check_log("miss100", 0, '0, 4, 32'h0000_0100);
        chk("miss100.lat", 32'(cyc), 32'd5);
        chk("miss100.data", rd, 32'hA000_0040);

        access(32'h0000_0104, 1'b0, '0, -1, cyc, rd);
        chk("hit104.lat", 32'(cyc), 32'd1);
        chk("hit104.data", rd, 32'hA000_0041);
        chk("hit104.no_mem", 32'(saw_req), 32'd0);

        access(32'h0000_0108, 1'b1, 32'hDEAD_BEEF, -1, cyc, rd);
        chk("st108.lat", 32'(cyc), 32'd1);
        chk("st108.no_mem", 32'(saw_req), 32'd0);
        access(32'h0000_0108, 1'b0, '0, -1, cyc, rd);
        chk("ld108.data", rd, 32'hDEAD_BEEF);

        access(32'h0000_0100, 1'b0, '0, -1, cyc, rd);
        chk("hit100.lat", 32'(cyc), 32'd1);
        access(32'h0000_1100, 1'b0, '0, -1, cyc, rd);
        chk("miss1100.lat", 32'(cyc), 32'd5);
        chk("miss1100.data", rd, 32'hA000_0440);

        access(32'h0000_2100, 1'b0, '0, -1, cyc, rd);
        check_log("evict", 4, 32'h0000_0100, 4, 32'h0000_2100);
        if (xfers.size() == 8) begin
            chk("evict.wd0", xfers[0].d, 32'hA000_0040);
            chk("evict.wd1", xfers[1].d, 32'hA000_0041);
            chk("evict.wd2", xfers[2].d, 32'hDEAD_BEEF);
            chk("evict.wd3", xfers[3].d, 32'hA000_0043);
        end
        chk("evict.lat", 32'(cyc), 32'd9);
        chk("evict.data", rd, 32'hA000_0840);

        // Round-robin now points at way 1 (0x1100, clean).
        access(32'h0000_3100, 1'b0, '0, -1, cyc, rd);
        chk("rr1.lat", 32'(cyc), 32'd5);
        access(32'h0000_2100, 1'b0, '0, -1, cyc, rd);
        chk("rr1.keep2100", 32'(cyc), 32'd1);
        access(32'h0000_1100, 1'b0, '0, -1, cyc, rd);
        chk("rr0.lat", 32'(cyc), 32'd5);
        access(32'h0000_3100, 1'b0, '0, -1, cyc, rd);
        chk("rr0.keep3100", 32'(cyc), 32'd1);

        stall_en = 1'b1;
        access(32'h0000_0318, 1'b0, '0, -1, cyc, rd);
        stall_en = 1'b0;
        chk("stall.lat", 32'(cyc), 32'd10);
        chk("stall.cycles", 32'(stall_cnt), 32'd5);
        chk("stall.addr_held", 32'(stall_addr_bad), 32'd0);
        chk("stall.data", rd, 32'hA000_00C6);
        check_log("stall", 0, '0, 4, 32'h0000_0310);

        access(32'h0000_0714, 1'b1, 32'h1234_5678, -1, cyc, rd);
        check_log("stmiss", 0, '0, 4, 32'h0000_0710);
        chk("stmiss.lat", 32'(cyc), 32'd5);
        access(32'h0000_0714, 1'b0, '0, -1, cyc, rd);
        chk("stmiss.merged", rd, 32'h1234_5678);
        chk("stmiss.hit", 32'(cyc), 32'd1);
        access(32'h0000_0718, 1'b0, '0, -1, cyc, rd);
        chk("stmiss.neighbour", rd, 32'hA000_01C6);

        access(32'h0000_0530, 1'b0, '0, 2, cyc, rd);
        check_log("ign", 0, '0, 4, 32'h0000_0530);
        chk("ign.lat", 32'(cyc), 32'd5);
        chk("ign.data", rd, 32'hA000_014C);
        access(32'h0000_0640, 1'b0, '0, -1, cyc, rd);
        chk("ign.other_miss", 32'(cyc), 32'd5);
        chk("ign.other_data", rd, 32'hA000_0190);

        @(posedge clock);
        #1;
        xfers.delete();
        address = 32'h0000_0420;
        should_write = 1'b0;
        request = 1'b1;
        for (int i = 0; i < 50 && xfers.size() < 2; i++) begin
            @(posedge clock);
            #1;
        end
        chk("rst_mid.words", 32'(xfers.size()), 32'd2);
        chk("rst_mid.req_before", 32'(mem_request), 32'd1);
        reset = 1'b1;
        request = 1'b0;
        #1;
        chk("rst_mid.req_drop", 32'(mem_request), 32'd0);
        chk("rst_mid.addr", mem_address, 32'd0);
        chk("rst_mid.ready", 32'(ready), 32'd0);
        #20;
        reset = 1'b0;
        access(32'h0000_0420, 1'b0, '0, -1, cyc, rd);
        check_log("rst_after", 0, '0, 4, 32'h0000_0420);
        chk("rst_after.lat", 32'(cyc), 32'd5);
        chk("rst_after.data", rd, 32'hA000_0108);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
